shift_sequencer: RTL

Command-driven controller for the team's 4-bit universal bidirectional shift register (hold / shift-left / shift-right / parallel-load, mode selected by S1:S0). It accepts one command at a time over a valid/ready handshake, optionally parallel-loads a value, then drives N shift or rotate cycles. It then pulses DONE. The block sits between a host FSM and the register, owns the register's S1, S0, DSR, DSL and P inputs, and reads Q back for rotation.

---
 rtl/shift_sequencer_pkg.sv | 27 ++
 rtl/shift_sequencer_if.sv | 34 +++
 rtl/shift_sequencer_counter.sv | 37 +++
 rtl/shift_sequencer.sv | 129 ++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Package: shift_seq_pkg
// Shared encodings for the shift_sequencer slice:
//   op_t    - command operation (rotate / serial-fill, left / right)
//   state_t - sequencer FSM state, also exported on the debug STATE port
//   MODE_*  - S1:S0 mode codes of the 4-bit universal shift register
package shift_seq_pkg;

  typedef enum logic [1:0] {
    OP_ROTL = 2'd0,  // rotate toward MSB, MSB wraps into bit 0
    OP_ROTR = 2'd1,  // rotate toward LSB, bit 0 wraps into MSB
    OP_SERL = 2'd2,  // shift toward MSB, SER_IN enters bit 0
    OP_SERR = 2'd3   // shift toward LSB, SER_IN enters MSB
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/shift_sequencer_if.sv
// Interface: shift_sequencer_if
// Command channel between the host FSM and shift_sequencer.
//   CMD_VALID/CMD_READY - handshake; a command transfers on a CLOCK posedge
//                         where both are high. VALID may be asserted at any
//                         time; READY is only high while the sequencer is IDLE,
//                         so a VALID held across a busy period is not taken
//                         until the sequencer returns to IDLE.
//   CMD_OP, CMD_LOAD, CMD_DATA, CMD_COUNT - command payload, sampled on transfer
//   BUSY  - sequencer is not IDLE
//   DONE  - one-cycle completion pulse
// Modports: master = host side, slave = sequencer side.
interface shift_sequencer_if #(
  parameter int LENGTH = 4,
  parameter int CW     = 3
);
  logic              CMD_VALID;
  logic              CMD_READY;
  logic [1:0]        CMD_OP;
  logic              CMD_LOAD;
  logic [LENGTH-1:0] CMD_DATA;
  logic [CW-1:0]     CMD_COUNT;
  logic              BUSY;
  logic              DONE;

  modport master (
    output CMD_VALID, CMD_OP, CMD_LOAD, CMD_DATA, CMD_COUNT,
    input  CMD_READY, BUSY, DONE
  );

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_LOAD, CMD_DATA, CMD_COUNT,
    output CMD_READY, BUSY, DONE
  );
endinterface

// File: rtl/shift_sequencer_counter.sv
// Module: shift_seq_counter
// CW-bit loadable down-counter that tracks the remaining shift cycles.
//   CLOCK  - clock
//   _MR    - synchronous active-low reset, clears the count
//   load   - load din (has priority over dec)
//   dec    - decrement by one; saturates at zero
//   din    - load value
//   count  - current value
//   is_one - count == 1, i.e. the current shift is the last one
module shift_seq_counter #(
  parameter int CW = 3
) (
  input  logic          CLOCK,
  input  logic          _MR,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] din,
  output logic [CW-1:0] count,
  output logic          is_one
);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLOCK) begin
    if (!_MR) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= din;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign count  = cnt;
  assign is_one = (cnt == CW'(1));

endmodule

// File: rtl/shift_sequencer.sv
// Module: shift_sequencer
// Command-driven controller for a 4-bit universal bidirectional shift
// register. Accepts one command at a time, optionally parallel-loads the
// register, drives COUNT shift/rotate cycles, then pulses DONE.
// Ports:
//   CLOCK     - clock, all state changes on posedge
//   _MR       - synchronous active-low reset
//   cmd       - command channel (shift_sequencer_if.slave)
//   SER_IN    - serial data for SERL/SERR, used live in each shift cycle
//   Q_IN      - register output, fed back for rotation
//   S1, S0    - register mode
//   DSR, DSL  - register serial inputs (bit 0 side / MSB side)
//   P         - register parallel input
//   STATE     - current FSM state (debug)
// Register-side outputs are decoded combinationally from the registered
// state so the register acts on the same edge that advances the FSM.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int LENGTH = 4,
  parameter int CW     = 3
) (
  input  logic              CLOCK,
  input  logic              _MR,
  shift_sequencer_if.slave  cmd,
  input  logic              SER_IN,
  input  logic [LENGTH-1:0] Q_IN,
  output logic              S1,
  output logic              S0,
  output logic              DSR,
  output logic              DSL,
  output logic [LENGTH-1:0] P,
  output state_t            STATE
);

  state_t            state, state_nxt;
  op_t               op_q;
  logic [LENGTH-1:0] data_q;
  logic [CW-1:0]     cnt;
  logic              cnt_is_one;
  logic              accept;
  logic [1:0]        mode;
  logic              dsr, dsl, done, ready;
  logic [LENGTH-1:0] p_drv;

  // Only the end bits of Q are needed to close the rotation loop.
  logic              unused_q_mid;
  assign unused_q_mid = ^Q_IN[LENGTH-2:1];

  // Counter is loaded on acceptance so LOAD can already see whether any
  // shifts follow; it steps once per SHIFT cycle.
  shift_seq_counter #(.CW(CW)) u_counter (
    .CLOCK  (CLOCK),
    ._MR    (_MR),
    .load   (accept),
    .dec    (state == ST_SHIFT),
    .din    (cmd.CMD_COUNT),
    .count  (cnt),
    .is_one (cnt_is_one)
  );

  always_ff @(posedge CLOCK) begin
    if (!_MR) begin
      state  <= ST_IDLE;
      op_q   <= OP_ROTL;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q   <= op_t'(cmd.CMD_OP);
        data_q <= cmd.CMD_DATA;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    ready     = 1'b0;
    done      = 1'b0;
    mode      = MODE_HOLD;
    dsr       = 1'b0;
    dsl       = 1'b0;
    p_drv     = '0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (cmd.CMD_VALID) begin
          accept = 1'b1;
          if (cmd.CMD_LOAD)              state_nxt = ST_LOAD;
          else if (cmd.CMD_COUNT != '0)  state_nxt = ST_SHIFT;
          else                           state_nxt = ST_FIN;
        end
      end
      ST_LOAD: begin
        mode      = MODE_LOAD;
        p_drv     = data_q;
        state_nxt = (cnt != '0) ? ST_SHIFT : ST_FIN;
      end
      ST_SHIFT: begin
        case (op_q)
          OP_ROTL: begin mode = MODE_SHL; dsr = Q_IN[LENGTH-1]; end
          OP_ROTR: begin mode = MODE_SHR; dsl = Q_IN[0];        end
          OP_SERL: begin mode = MODE_SHL; dsr = SER_IN;         end
          OP_SERR: begin mode = MODE_SHR; dsl = SER_IN;         end
          default: mode = MODE_HOLD;
        endcase
        // Last shift happens in this cycle; FIN follows directly.
        if (cnt_is_one) state_nxt = ST_FIN;
      end
      ST_FIN: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign S1            = mode[1];
  assign S0            = mode[0];
  assign DSR           = dsr;
  assign DSL           = dsl;
  assign P             = p_drv;
  assign STATE         = state;
  assign cmd.CMD_READY = ready;
  assign cmd.DONE      = done;
  assign cmd.BUSY      = (state != ST_IDLE);

endmodule
